// File: rtl/ram_stream_pkg.sv
// Shared types and helpers for the RAM burst read engine.
package ram_stream_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  // Smallest power of two that is >= n.
  function automatic int pow2_ceil(input int n);
    int p;
    p = 1;
    for (int i = 0; i < 31; i++) if (p < n) p = p * 2;
    return p;
  endfunction

  // Address increment that wraps at the RAM depth rather than at 2^width.
  function automatic logic [31:0] addr_inc(input logic [31:0] a, input int depth);
    return (a == 32'(depth - 1)) ? 32'd0 : a + 32'd1;
  endfunction

endpackage

// File: rtl/ram_stream_fifo.sv
// Return buffer for RAM read data: power-of-two synchronous FIFO, head read straight
// from the storage registers so the stream side never sees RAM data combinationally.
module ram_stream_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full buffer is fine when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  overflow_chk: assert property (@(posedge gclk) disable iff (!grst_n) !(push && full && !pop));

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read engine on a RAM port: issues back-to-back reads for (addr, len) commands
// under a credit limit and returns the words as a valid/ready stream with tlast.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int MEM_WIDTH  = 32,
  parameter int BYTE_NUM   = 4,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int LEN_WIDTH  = 16,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = pow2_ceil(RD_LATENCY + 2)
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  output logic                  ram_en_o,
  output logic                  ram_rd_en_o,
  output logic [BYTE_NUM-1:0]   ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [MEM_WIDTH-1:0]  ram_data_i,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic [MEM_WIDTH-1:0]  m_tdata_o,
  output logic                  m_tlast_o,
  output logic                  busy_o,
  output logic                  done_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                  state, state_nxt;
  logic                    armed, issue, cmd_fire, push, pop, fifo_empty, credit_ok;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [LEN_WIDTH-1:0]    len, beat_cnt;
  logic [LEN_WIDTH:0]      issue_left;
  logic [RD_LATENCY-1:0]   vld_pipe;
  logic [CW-1:0]           inflight, fifo_cnt;
  logic [MEM_WIDTH:0]      fifo_head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(vld_pipe[i]);
  end

  // Every read in flight owns a FIFO slot, so the buffer can never overflow.
  assign credit_ok = (32'(inflight) + 32'(fifo_cnt)) < 32'(FIFO_DEPTH);

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    cmd_ready_o = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = armed;
        if (armed && cmd_valid_i) state_nxt = READ;
      end
      READ: begin
        issue = (issue_left != '0) && credit_ok;
        if (issue && issue_left == {{LEN_WIDTH{1'b0}}, 1'b1}) state_nxt = DRAIN;
      end
      DRAIN: if (pop && fifo_head[MEM_WIDTH]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_fire = cmd_ready_o & cmd_valid_i;
  assign push     = vld_pipe[RD_LATENCY-1];
  assign pop      = ~fifo_empty & m_tready_i;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      armed      <= 1'b0;
      addr       <= '0;
      len        <= '0;
      issue_left <= '0;
      beat_cnt   <= '0;
      vld_pipe   <= '0;
    end else begin
      state <= state_nxt;
      // Holds cmd_ready low until the first clock after reset release.
      armed <= 1'b1;
      if (cmd_fire) begin
        addr       <= cmd_addr_i;
        len        <= cmd_len_i;
        issue_left <= {1'b0, cmd_len_i} + 1'b1;
        beat_cnt   <= '0;
      end else begin
        if (issue) begin
          addr       <= ADDR_WIDTH'(addr_inc(32'(addr), MEM_DEPTH));
          issue_left <= issue_left - 1'b1;
        end
        if (push) beat_cnt <= beat_cnt + 1'b1;
      end
      vld_pipe[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // tlast is tagged on entry so it stays with its word regardless of stalls.
  ram_stream_fifo #(
    .W     (MEM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .gclk      (clk_i),
    .grst_n    (arstn_i),
    .push      (push),
    .push_data ({beat_cnt == len, ram_data_i}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign m_tvalid_o  = ~fifo_empty;
  assign m_tdata_o   = fifo_head[MEM_WIDTH-1:0];
  assign m_tlast_o   = fifo_head[MEM_WIDTH];
  assign done_o      = (state == DRAIN) & pop & fifo_head[MEM_WIDTH];
  assign busy_o      = (state != IDLE);
  assign ram_rd_en_o = busy_o;
  assign ram_en_o    = issue;
  assign ram_addr_o  = addr;
  assign ram_wr_en_o = '0;

endmodule
